// File: rtl/extmem_port.sv
// External-memory model for the core bus: LATENCY wait cycles, then one beat per cycle.
// Writes are single beat with byte lanes. Reads may burst up to 4 beats and wrap at 2^ADR_W.
module extmem_port #(
    parameter int    DATA_W    = 32,
    parameter int    ADR_W     = 11,
    parameter int    DEPTH     = 1024,
    parameter int    LATENCY   = 2,
    parameter string INIT_FILE = ""
) (
    input  logic                ph1,
    input  logic                reset,
    input  logic                en,
    input  logic                rwb,
    input  logic [ADR_W-1:0]    adr,
    input  logic [DATA_W/8-1:0] byteen,
    input  logic [1:0]          blen,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata,
    output logic                done,
    output logic                busy,
    output logic                err
);
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = 4;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_XFER = 2'd2;

    localparam logic [ADR_W:0]   DEPTH_L = (ADR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAT_L   = CNT_W'(LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]        state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [ADR_W-1:0]  adr_reg;
    logic              rwb_reg;
    logic [NB-1:0]     byteen_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [1:0]        blen_reg;
    logic [1:0]        beat_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              done_reg;
    logic              busy_reg;
    logic              err_reg;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              wr_beat;
    logic              rd_beat;

    assign in_range = ({1'b0, adr_reg} < DEPTH_L);
    assign idx      = adr_reg[IDX_W-1:0];
    assign wr_beat  = (state_reg == S_XFER) && !rwb_reg && in_range;
    assign rd_beat  = (state_reg == S_XFER) && rwb_reg;

    // RAM has no reset so it maps onto block RAM; contents survive a reset.
    always_ff @(posedge ph1) begin
        if (wr_beat) begin
            for (int i = 0; i < NB; i++) begin
                if (byteen_reg[i]) begin
                    mem[idx][i*8 +: 8] <= wdata_reg[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            rdata_reg <= '0;
        end else if (rd_beat) begin
            rdata_reg <= in_range ? mem[idx] : '0;
        end
    end

    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            adr_reg    <= '0;
            rwb_reg    <= 1'b0;
            byteen_reg <= '0;
            wdata_reg  <= '0;
            blen_reg   <= '0;
            beat_reg   <= '0;
            done_reg   <= 1'b0;
            busy_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (en) begin
                        adr_reg    <= adr;
                        rwb_reg    <= rwb;
                        byteen_reg <= byteen;
                        wdata_reg  <= wdata;
                        blen_reg   <= rwb ? blen : 2'd0;
                        beat_reg   <= '0;
                        cnt_reg    <= LAT_L;
                        busy_reg   <= 1'b1;
                        state_reg  <= (LATENCY > 0) ? S_WAIT : S_XFER;
                    end
                end
                S_WAIT: begin
                    cnt_reg <= cnt_reg - CNT_ONE;
                    if (cnt_reg == CNT_ONE) begin
                        state_reg <= S_XFER;
                    end
                end
                S_XFER: begin
                    done_reg <= 1'b1;
                    err_reg  <= !in_range;
                    adr_reg  <= adr_reg + 1'b1;
                    beat_reg <= beat_reg + 1'b1;
                    // busy drops with the last beat so a request in the done cycle is taken.
                    if (beat_reg == blen_reg) begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata = rdata_reg;
    assign done  = done_reg;
    assign busy  = busy_reg;
    assign err   = err_reg;

endmodule
